// File: rtl/fetch_decode_control.sv
// fetch_decode_control
//   Program counter, fetch sequencer and instruction decoder for the
//   accumulator CPU. Addr drives the program memory. That memory registers
//   its Data output on the falling clock edge, so Instr_In holds the word
//   for the current Addr during the second half of each cycle. Each word is
//   decoded into datapath strobes. The sequencer runs until it executes HLT
//   and then stops.
//
// Ports
//   clk          in   system clock, state updates on posedge
//   reset        in   asynchronous, active-high
//   enable       in   1 = execute, 0 = stall (PC, state, counter hold)
//   Instr_In     in   [DB-1:0] instruction word for current Addr
//   Addr         out  [AB-1:0] program counter
//   Operand      out  [DB-OPB-1:0] low instruction field, passthrough
//   WrRAM        out  data-memory write strobe
//   RdRAM        out  data-memory read strobe
//   SelA         out  [1:0] acc mux: 00 mem, 01 immediate, 10 ALU
//   SelB         out  ALU B operand: 0 mem, 1 immediate
//   WrAcc        out  accumulator load enable
//   Op           out  ALU op: 0 add, 1 sub
//   Halted       out  registered, 1 once HLT has executed
//   Instr_Count  out  [CB-1:0] executed instructions, saturating
//
// State | Meaning
// PRIME | first cycle after reset; memory fetches Mem[0], no strobes
// RUN   | decode Instr_In, advance PC and counter when enabled
// HALT  | absorbing after HLT; everything frozen until reset

module fetch_decode_control #(
  parameter int AB  = 11,
  parameter int DB  = 16,
  parameter int OPB = 5,
  parameter int CB  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DB-1:0]     Instr_In,
  output logic [AB-1:0]     Addr,
  output logic [DB-OPB-1:0] Operand,
  output logic              WrRAM,
  output logic              RdRAM,
  output logic [1:0]        SelA,
  output logic              SelB,
  output logic              WrAcc,
  output logic              Op,
  output logic              Halted,
  output logic [CB-1:0]     Instr_Count
);

  typedef enum logic [1:0] {PRIME, RUN, HALT} state_t;

  localparam logic [OPB-1:0] OP_HLT  = OPB'(0);
  localparam logic [OPB-1:0] OP_STO  = OPB'(1);
  localparam logic [OPB-1:0] OP_LD   = OPB'(2);
  localparam logic [OPB-1:0] OP_LDI  = OPB'(3);
  localparam logic [OPB-1:0] OP_ADD  = OPB'(4);
  localparam logic [OPB-1:0] OP_ADDI = OPB'(5);
  localparam logic [OPB-1:0] OP_SUB  = OPB'(6);
  localparam logic [OPB-1:0] OP_SUBI = OPB'(7);

  state_t          state_q, state_d;
  logic [AB-1:0]   pc_q, pc_d;
  logic [CB-1:0]   cnt_q, cnt_d;
  logic            halted_q;
  logic [OPB-1:0]  opcode;

  assign opcode      = Instr_In[DB-1:DB-OPB];
  assign Operand     = Instr_In[DB-OPB-1:0];
  assign Addr        = pc_q;
  assign Instr_Count = cnt_q;
  assign Halted      = halted_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= PRIME;
      pc_q     <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == HALT);
    end
  end

  // Instr_In is examined only in the RUN branch. An X on the bus in any
  // other state therefore cannot reach the strobes.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    WrRAM   = 1'b0;
    RdRAM   = 1'b0;
    SelA    = 2'b00;
    SelB    = 1'b0;
    WrAcc   = 1'b0;
    Op      = 1'b0;
    case (state_q)
      PRIME: state_d = RUN;
      RUN: begin
        if (enable) begin
          if (cnt_q != '1) cnt_d = cnt_q + CB'(1);
          if (opcode == OP_HLT) begin
            state_d = HALT;
          end else begin
            // The PC wraps naturally at 2^AB.
            pc_d = pc_q + AB'(1);
            case (opcode)
              OP_STO:  WrRAM = 1'b1;
              OP_LD:   begin RdRAM = 1'b1; WrAcc = 1'b1; end
              OP_LDI:  begin SelA = 2'b01; WrAcc = 1'b1; end
              OP_ADD:  begin RdRAM = 1'b1; SelA = 2'b10; WrAcc = 1'b1; end
              OP_ADDI: begin SelA = 2'b10; SelB = 1'b1; WrAcc = 1'b1; end
              OP_SUB:  begin RdRAM = 1'b1; SelA = 2'b10; Op = 1'b1; WrAcc = 1'b1; end
              OP_SUBI: begin SelA = 2'b10; SelB = 1'b1; Op = 1'b1; WrAcc = 1'b1; end
              default: ;
            endcase
          end
        end
      end
      HALT: ;
      default: state_d = PRIME;
    endcase
  end

endmodule

// File: tb/tb_fetch_decode_control.sv
// Directed bench for fetch_decode_control. A behavioural program memory
// registers mem[Addr] on the falling clock edge. Outputs are sampled 1 time
// unit after that edge. At that point Instr_In already holds the word for the
// current Addr.
module tb_fetch_decode_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] instr_in = 'x;
  logic [10:0] addr;
  logic [10:0] operand;
  logic        wr_ram, rd_ram, sel_b, wr_acc, op, halted;
  logic [1:0]  sel_a;
  logic [15:0] instr_count;

  logic [15:0] mem [0:2047];

  int tests = 0;
  int fails = 0;

  // Strobe vector {WrRAM, RdRAM, SelA[1:0], SelB, WrAcc, Op}
  logic [6:0]  exp_strb [0:7] = '{7'b1000000, 7'b0100010, 7'b0001010, 7'b0110010,
                                  7'b0010110, 7'b0110011, 7'b0010111, 7'b0000000};
  logic [15:0] prog     [0:7] = '{16'h0801, 16'h1002, 16'h1803, 16'h2004,
                                  16'h2805, 16'h3006, 16'h3807, 16'h0000};
  logic [10:0] exp_opnd [0:7] = '{11'd1, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6, 11'd7, 11'd0};

  fetch_decode_control dut (
    .clk(clk), .reset(reset), .enable(enable), .Instr_In(instr_in),
    .Addr(addr), .Operand(operand), .WrRAM(wr_ram), .RdRAM(rd_ram),
    .SelA(sel_a), .SelB(sel_b), .WrAcc(wr_acc), .Op(op),
    .Halted(halted), .Instr_Count(instr_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!reset) instr_in = mem[addr];

  function automatic logic [6:0] strb();
    return {wr_ram, rd_ram, sel_a, sel_b, wr_acc, op};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 8; i++) mem[i] = prog[i];
  endtask

  // Reset is released just after a rising edge, so the PRIME cycle is the
  // rest of that clock period. Instr_In is X until the first falling edge.
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; enable = 1'b1; instr_in = 'x;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("prime_x_strb", 32'(strb()), 32'd0);
    check("prime_x_addr", 32'(addr), 32'd0);
    @(negedge clk); #1;
    check("prime_valid_strb", 32'(strb()), 32'd0);
    check("prime_addr", 32'(addr), 32'd0);
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  initial begin
    // 1: full program through HLT
    load_prog();
    do_reset();
    check("reset_cnt", 32'(instr_count), 32'd0);
    check("reset_halted", 32'(halted), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("p1_addr%0d", i), 32'(addr), 32'(i));
      check($sformatf("p1_strb%0d", i), 32'(strb()), 32'(exp_strb[i]));
      check($sformatf("p1_opnd%0d", i), 32'(operand), 32'(exp_opnd[i]));
      check($sformatf("p1_cnt%0d", i), 32'(instr_count), 32'(i));
      check($sformatf("p1_halt%0d", i), 32'(halted), 32'd0);
    end
    step();
    check("p1_halted", 32'(halted), 32'd1);
    check("p1_halt_addr", 32'(addr), 32'd7);
    check("p1_halt_cnt", 32'(instr_count), 32'd8);
    check("p1_halt_strb", 32'(strb()), 32'd0);
    enable = 1'b0; step(); enable = 1'b1; step();
    check("p1_frozen_addr", 32'(addr), 32'd7);
    check("p1_frozen_cnt", 32'(instr_count), 32'd8);
    check("p1_frozen_halted", 32'(halted), 32'd1);

    // 3: stall for three cycles on the ADD at address 3
    load_prog();
    do_reset();
    repeat (4) step();
    check("p3_addr_pre", 32'(addr), 32'd3);
    check("p3_strb_pre", 32'(strb()), 32'(exp_strb[3]));
    enable = 1'b0;
    #1 check("p3_strb_drop", 32'(strb()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("p3_stall_strb%0d", i), 32'(strb()), 32'd0);
      check($sformatf("p3_stall_addr%0d", i), 32'(addr), 32'd3);
      check($sformatf("p3_stall_cnt%0d", i), 32'(instr_count), 32'd3);
    end
    enable = 1'b1;
    #1 check("p3_resume_strb", 32'(strb()), 32'(exp_strb[3]));
    step();
    check("p3_next_addr", 32'(addr), 32'd4);
    check("p3_next_cnt", 32'(instr_count), 32'd4);
    check("p3_next_strb", 32'(strb()), 32'(exp_strb[4]));

    // 4: opcode 11111 behaves as NOP
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1803; mem[1] = 16'h0801; mem[2] = 16'hFFFF;
    do_reset();
    repeat (3) step();
    check("p4_nop_addr", 32'(addr), 32'd2);
    check("p4_nop_strb", 32'(strb()), 32'd0);
    check("p4_nop_opnd", 32'(operand), 32'h7FF);
    step();
    check("p4_after_addr", 32'(addr), 32'd3);
    check("p4_after_cnt", 32'(instr_count), 32'd3);
    check("p4_after_halt", 32'(halted), 32'd0);

    // 5: PC wrap on a NOP-only memory
    for (int i = 0; i < 2048; i++) mem[i] = 16'h4000;
    do_reset();
    repeat (2048) step();
    check("p5_top_addr", 32'(addr), 32'd2047);
    check("p5_top_cnt", 32'(instr_count), 32'd2047);
    check("p5_top_strb", 32'(strb()), 32'd0);
    step();
    check("p5_wrap_addr", 32'(addr), 32'd0);
    check("p5_wrap_cnt", 32'(instr_count), 32'd2048);
    check("p5_wrap_halt", 32'(halted), 32'd0);

    // 6: asynchronous reset in the middle of an ADD
    load_prog();
    do_reset();
    repeat (4) step();
    check("p6_add_strb", 32'(strb()), 32'(exp_strb[3]));
    #2 reset = 1'b1;
    #1;
    check("p6_async_strb", 32'(strb()), 32'd0);
    check("p6_async_addr", 32'(addr), 32'd0);
    check("p6_async_cnt", 32'(instr_count), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    check("p6_prime_strb", 32'(strb()), 32'd0);
    check("p6_prime_addr", 32'(addr), 32'd0);
    step();
    check("p6_prime2_strb", 32'(strb()), 32'd0);
    step();
    check("p6_run_addr", 32'(addr), 32'd0);
    check("p6_run_strb", 32'(strb()), 32'(exp_strb[0]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
